multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM: sequences fetch/decode/execute/writeback
// steps, raises a sticky illegal flag on unsupported opcodes, counts retirements.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       imm_src,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t cur_state;
  state_t next_state;
  logic   retire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur_state <= S_FETCH;
    else        cur_state <= next_state;
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_JAL:       next_state = S_JAL;
          OP_BEQ:       next_state = S_BEQ;
          default:      next_state = S_TRAP;
        endcase
      end
      S_MEMADR:   next_state = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
      S_EXECR:    next_state = S_ALUWB;
      S_EXECI:    next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      S_BEQ:      next_state = S_FETCH;
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (cur_state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB:  reg_write = 1'b1;
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero;
      end
      default: ;
    endcase
    // Reset kills every strobe at once so an in-flight access cannot write.
    if (!reset) begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b10;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b10;
      alu_op     = 2'b00;
    end
  end

  always_comb begin
    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Every non-FETCH state that falls back to FETCH ends exactly one instruction.
  assign retire = (next_state == S_FETCH) && (cur_state != S_FETCH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      if (next_state == S_TRAP) illegal <= 1'b1;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control words are
// queued by the driver and checked by an independent negedge monitor.
module tb_multicycle_controller;

  localparam int CNT_W = 4;
  localparam int W = 25;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                         MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, ALUWB = 4'd7,
                         EXECI = 4'd8, JAL = 4'd9, BEQ = 4'd10, TRAP = 4'd11;

  logic             clk;
  logic             reset;
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write, adr_src, mem_read, mem_write, ir_write, reg_write;
  logic [1:0]       result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     exp_w, act_w;
  logic [CNT_W-1:0] exp_ret;
  logic             exp_ill;
  int               n_tests;
  int               n_failed;

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
    .illegal(illegal), .state(state), .retired(retired)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected control bits:
  // {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
  //  result_src, alu_src_a, alu_src_b, alu_op, imm_src}
  function automatic logic [15:0] ctrl(input logic [3:0] st, input logic [6:0] op,
                                       input logic z, input logic mr, input logic in_rst);
    logic [1:0] imm;
    imm = (op == OP_SW) ? 2'b01 : (op == OP_BEQ) ? 2'b10 : (op == OP_JAL) ? 2'b11 : 2'b00;
    if (in_rst) return {6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, imm};
    case (st)
      FETCH:    return {mr, 1'b0, 1'b1, 1'b0, mr, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, imm};
      DECODE:   return {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, imm};
      MEMADR:   return {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, imm};
      MEMREAD:  return {6'b011000, 2'b00, 2'b00, 2'b00, 2'b00, imm};
      MEMWB:    return {6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, imm};
      MEMWRITE: return {6'b010100, 2'b00, 2'b00, 2'b00, 2'b00, imm};
      EXECR:    return {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, imm};
      EXECI:    return {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10, imm};
      ALUWB:    return {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, imm};
      JAL:      return {6'b100000, 2'b00, 2'b01, 2'b10, 2'b00, imm};
      BEQ:      return {z, 5'b00000, 2'b00, 2'b10, 2'b00, 2'b01, imm};
      default:  return {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, imm};
    endcase
  endfunction

  // driver tasks
  task automatic step(input logic [6:0] op, input logic z, input logic mr,
                      input logic [3:0] es);
    @(posedge clk);
    #1;
    opcode = op;
    zero = z;
    mem_ready = mr;
    exp_q.push_back({es, ctrl(es, op, z, mr, 1'b0), exp_ill, exp_ret});
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    reset = 1'b0;
    exp_ret = '0;
    exp_ill = 1'b0;
    exp_q.push_back({FETCH, ctrl(FETCH, opcode, zero, 1'b0, 1'b1), 1'b0, {CNT_W{1'b0}}});
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic do_alu(input logic [6:0] op);
    step(op, 1'b0, 1'b1, FETCH);
    step(op, 1'b0, 1'b1, DECODE);
    step(op, 1'b0, 1'b1, (op == OP_R) ? EXECR : EXECI);
    step(op, 1'b0, 1'b0, ALUWB);
    exp_ret = exp_ret + 1'b1;
  endtask

  task automatic do_lw(input int waits);
    step(OP_LW, 1'b0, 1'b0, FETCH);
    step(OP_LW, 1'b0, 1'b1, FETCH);
    step(OP_LW, 1'b0, 1'b0, DECODE);
    step(OP_LW, 1'b0, 1'b1, MEMADR);
    for (int i = 0; i < waits; i++) step(OP_LW, 1'b1, 1'b0, MEMREAD);
    step(OP_LW, 1'b0, 1'b1, MEMREAD);
    step(OP_LW, 1'b0, 1'b1, MEMWB);
    exp_ret = exp_ret + 1'b1;
  endtask

  task automatic do_sw_start();
    step(OP_SW, 1'b0, 1'b1, FETCH);
    step(OP_SW, 1'b0, 1'b1, DECODE);
    step(OP_SW, 1'b0, 1'b0, MEMADR);
    step(OP_SW, 1'b0, 1'b0, MEMWRITE);
  endtask

  task automatic do_sw();
    do_sw_start();
    step(OP_SW, 1'b0, 1'b1, MEMWRITE);
    exp_ret = exp_ret + 1'b1;
  endtask

  task automatic do_beq(input logic z);
    step(OP_BEQ, z, 1'b1, FETCH);
    step(OP_BEQ, z, 1'b0, DECODE);
    step(OP_BEQ, z, 1'b1, BEQ);
    exp_ret = exp_ret + 1'b1;
  endtask

  task automatic do_jal();
    step(OP_JAL, 1'b0, 1'b1, FETCH);
    step(OP_JAL, 1'b0, 1'b1, DECODE);
    step(OP_JAL, 1'b0, 1'b1, JAL);
    step(OP_JAL, 1'b0, 1'b0, ALUWB);
    exp_ret = exp_ret + 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      act_w = {state, pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal, retired};
      n_tests++;
      if (act_w !== exp_w) begin
        n_failed++;
        $display("FAIL ctrl_word t=%0t: actual state=%0d word=%h, required state=%0d word=%h",
                 $time, act_w[W-1 -: 4], act_w, exp_w[W-1 -: 4], exp_w);
      end
    end
  end

  initial begin
    n_tests = 0;
    n_failed = 0;
    exp_ret = '0;
    exp_ill = 1'b0;
    reset = 1'b0;
    opcode = 7'd0;
    zero = 1'b0;
    mem_ready = 1'b0;
    #1;
    exp_q.push_back({FETCH, ctrl(FETCH, 7'd0, 1'b0, 1'b0, 1'b1), 1'b0, {CNT_W{1'b0}}});
    #11;
    reset = 1'b1;

    do_alu(OP_R);
    do_lw(3);
    do_beq(1'b1);
    do_beq(1'b0);
    do_jal();
    do_alu(OP_I);
    do_sw();

    // abort a store mid-access; retired restarts at zero
    do_sw_start();
    reset_pulse();
    step(OP_SW, 1'b0, 1'b0, FETCH);

    // preload to all-ones, then one store wraps the counter
    for (int i = 0; i < 15; i++) begin
      case (i % 4)
        0: do_alu(OP_R);
        1: do_alu(OP_I);
        2: do_beq(i[3]);
        default: do_jal();
      endcase
    end
    do_sw();
    step(OP_R, 1'b0, 1'b0, FETCH);

    // unsupported opcode traps and stays put
    step(7'd0, 1'b0, 1'b1, FETCH);
    step(7'd0, 1'b0, 1'b1, DECODE);
    exp_ill = 1'b1;
    for (int i = 0; i < 20; i++) step(7'd0, i[0], i[1], TRAP);
    reset_pulse();
    step(OP_R, 1'b0, 1'b0, FETCH);

    @(negedge clk);
    #1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_failed++;
      $display("FAIL drain: actual %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
